wav_dfi_phy_responder: RTL and testbench

- PHY-side handshake engine for the DFI control interface.
- Responds to MC-initiated lp_ctrl, lp_data and ctrlupd requests with correctly timed acks.
- Initiates phyupd requests on behalf of PHY-internal calibration logic.
- Sits between the DFI boundary and PHY housekeeping logic; it is the responder the DFI agent's MC-side driver talks to.

---
 rtl/wav_dfi_phy_resp_pkg.sv | 47 ++++
 rtl/wav_dfi_phy_responder_if.sv | 27 ++
 rtl/wav_dfi_lp_hs.sv | 74 +++++++
 rtl/wav_dfi_phy_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_wav_dfi_phy_responder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wav_dfi_phy_resp_pkg.sv
// Shared types, widths and default timing for the DFI PHY-side handshake responder.
package wav_dfi_phy_resp_pkg;

  localparam int unsigned LP_ACK_DLY_DEF      = 4;
  localparam int unsigned CTRLUPD_ACK_DLY_DEF = 2;
  localparam int unsigned TPHYUPD_RESP_DEF    = 16;
  localparam int unsigned PHYUPD_HOLD_DEF     = 8;

  localparam int unsigned DLY_W  = 4;
  localparam int unsigned WAKE_W = 6;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    LP_IDLE = 2'd0,
    LP_WAIT = 2'd1,
    LP_ACK  = 2'd2,
    LP_REJ  = 2'd3
  } lp_st_e;

  typedef enum logic [1:0] {
    CU_IDLE = 2'd0,
    CU_WAIT = 2'd1,
    CU_ACK  = 2'd2
  } cu_st_e;

  typedef enum logic [1:0] {
    PU_IDLE = 2'd0,
    PU_REQ  = 2'd1,
    PU_HOLD = 2'd2,
    PU_DROP = 2'd3
  } pu_st_e;

  typedef enum logic [1:0] {
    PU_TYPE_0 = 2'd0,
    PU_TYPE_1 = 2'd1,
    PU_TYPE_2 = 2'd2,
    PU_TYPE_3 = 2'd3
  } pu_type_e;

  // Saturating add of a small increment onto a statistics counter.
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] v, input logic [1:0] n);
    logic [STAT_W:0] s;
    s = {1'b0, v} + {{(STAT_W-1){1'b0}}, n};
    return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/wav_dfi_phy_responder_if.sv
// DFI control-interface signals between the MC (master) and the PHY responder (slave).
interface wav_dfi_phy_responder_if;
  import wav_dfi_phy_resp_pkg::*;

  logic              lp_ctrl_req;
  logic [WAKE_W-1:0] lp_ctrl_wakeup;
  logic              lp_ctrl_ack;
  logic              lp_data_req;
  logic [WAKE_W-1:0] lp_data_wakeup;
  logic              lp_data_ack;
  logic              ctrlupd_req;
  logic              ctrlupd_ack;
  logic              phyupd_req;
  pu_type_e          phyupd_type;
  logic              phyupd_ack;

  modport master (
    output lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup, ctrlupd_req, phyupd_ack,
    input  lp_ctrl_ack, lp_data_ack, ctrlupd_ack, phyupd_req, phyupd_type
  );

  modport slave (
    input  lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup, ctrlupd_req, phyupd_ack,
    output lp_ctrl_ack, lp_data_ack, ctrlupd_ack, phyupd_req, phyupd_type
  );

endinterface

// File: rtl/wav_dfi_lp_hs.sv
// One DFI low-power handshake channel: delayed ack, abort, reject and wakeup-code latch.
module wav_dfi_lp_hs
  import wav_dfi_phy_resp_pkg::*;
#(
  parameter int unsigned ACK_DLY = LP_ACK_DLY_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [WAKE_W-1:0] wakeup,
  input  logic              allow,
  output logic              ack,
  output logic [WAKE_W-1:0] wakeup_q,
  output lp_st_e            state,
  output logic              start_c,
  output logic              rej_c
);

  lp_st_e           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             ack_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_c = 1'b0;
    rej_c   = 1'b0;
    unique case (state_q)
      LP_IDLE: begin
        if (req && allow) begin
          state_d = LP_WAIT;
          cnt_d   = DLY_W'(ACK_DLY);
          start_c = 1'b1;
        end else if (req) begin
          state_d = LP_REJ;
          rej_c   = 1'b1;
        end
      end
      LP_WAIT: begin
        if (!req) begin
          state_d = LP_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= DLY_W'(1)) begin
          state_d = LP_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      LP_ACK:  if (!req) state_d = LP_IDLE;
      LP_REJ:  if (!req) state_d = LP_IDLE;
      default: state_d = LP_IDLE;
    endcase
  end

  // Wakeup code is captured only when a request is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= LP_IDLE;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      wakeup_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_d == LP_ACK);
      if (start_c) wakeup_q <= wakeup;
    end
  end

  assign ack   = ack_q;
  assign state = state_q;

endmodule

// File: rtl/wav_dfi_phy_responder.sv
// PHY-side DFI handshake engine: lp_ctrl/lp_data/ctrlupd responder and phyupd initiator.
// Optional statistics counters are built when WAV_DFI_PHY_RESP_STATS_EN is defined.
module wav_dfi_phy_responder
  import wav_dfi_phy_resp_pkg::*;
#(
  parameter int unsigned LP_ACK_DLY      = LP_ACK_DLY_DEF,
  parameter int unsigned CTRLUPD_ACK_DLY = CTRLUPD_ACK_DLY_DEF,
  parameter int unsigned TPHYUPD_RESP    = TPHYUPD_RESP_DEF,
  parameter int unsigned PHYUPD_HOLD     = PHYUPD_HOLD_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  wav_dfi_phy_responder_if.slave   dfi,
  input  logic                     lp_allow,
  input  logic                     phyupd_start,
  input  pu_type_e                 phyupd_type_in,
  output logic [WAKE_W-1:0]        lp_ctrl_wakeup_q,
  output logic [WAKE_W-1:0]        lp_data_wakeup_q,
  output logic                     upd_window,
  output logic                     phyupd_busy,
  output logic                     phyupd_timeout
`ifdef WAV_DFI_PHY_RESP_STATS_EN
  ,
  output logic [STAT_W-1:0]        lp_ack_cnt,
  output logic [STAT_W-1:0]        ctrlupd_ack_cnt,
  output logic [STAT_W-1:0]        phyupd_cnt,
  output logic [STAT_W-1:0]        lp_rej_cnt
`endif
);

  localparam int unsigned RESP_W = $clog2(TPHYUPD_RESP + 1);
  localparam int unsigned HOLD_W = $clog2(PHYUPD_HOLD + 1);

  pu_st_e            pu_q, pu_d;
  logic              pu_pend_q, pu_pend_d;
  pu_type_e          pu_type_q, pu_type_d;
  logic [RESP_W-1:0] pu_wait_q, pu_wait_d;
  logic [HOLD_W-1:0] pu_hold_q, pu_hold_d;
  logic              pu_tmo_q, pu_tmo_d;
  logic              pu_req_q, pu_busy_q;
  logic              pu_go_c;

  cu_st_e            cu_q, cu_d;
  logic [DLY_W-1:0]  cu_cnt_q, cu_cnt_d;
  logic              cu_ack_q;
  logic              cu_go_c;

  lp_st_e            lp_c_st, lp_d_st;
  logic              lp_c_ack, lp_d_ack;
  logic              lp_c_start, lp_d_start, lp_c_rej, lp_d_rej;
  logic              lp_grant;

  assign lp_grant = lp_allow && (pu_q == PU_IDLE);

  wav_dfi_lp_hs #(.ACK_DLY(LP_ACK_DLY)) u_lp_ctrl (
    .clock    (clock),
    .reset    (reset),
    .req      (dfi.lp_ctrl_req),
    .wakeup   (dfi.lp_ctrl_wakeup),
    .allow    (lp_grant),
    .ack      (lp_c_ack),
    .wakeup_q (lp_ctrl_wakeup_q),
    .state    (lp_c_st),
    .start_c  (lp_c_start),
    .rej_c    (lp_c_rej)
  );

  wav_dfi_lp_hs #(.ACK_DLY(LP_ACK_DLY)) u_lp_data (
    .clock    (clock),
    .reset    (reset),
    .req      (dfi.lp_data_req),
    .wakeup   (dfi.lp_data_wakeup),
    .allow    (lp_grant),
    .ack      (lp_d_ack),
    .wakeup_q (lp_data_wakeup_q),
    .state    (lp_d_st),
    .start_c  (lp_d_start),
    .rej_c    (lp_d_rej)
  );

  // ctrlupd is held off while the PHY owns the update window or an LP ack is up.
  assign cu_go_c = (cu_q == CU_IDLE) && dfi.ctrlupd_req && !pu_req_q &&
                   (lp_c_st != LP_ACK) && (lp_d_st != LP_ACK);

  always_comb begin
    cu_d     = cu_q;
    cu_cnt_d = cu_cnt_q;
    unique case (cu_q)
      CU_IDLE: begin
        if (cu_go_c) begin
          cu_d     = CU_WAIT;
          cu_cnt_d = DLY_W'(CTRLUPD_ACK_DLY);
        end
      end
      CU_WAIT: begin
        if (!dfi.ctrlupd_req) begin
          cu_d     = CU_IDLE;
          cu_cnt_d = '0;
        end else if (cu_cnt_q <= DLY_W'(1)) begin
          cu_d     = CU_ACK;
          cu_cnt_d = '0;
        end else begin
          cu_cnt_d = cu_cnt_q - DLY_W'(1);
        end
      end
      CU_ACK:  if (!dfi.ctrlupd_req) cu_d = CU_IDLE;
      default: cu_d = CU_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cu_q     <= CU_IDLE;
      cu_cnt_q <= '0;
      cu_ack_q <= 1'b0;
    end else begin
      cu_q     <= cu_d;
      cu_cnt_q <= cu_cnt_d;
      cu_ack_q <= (cu_d == CU_ACK);
    end
  end

  // MC-side requests (LP or ctrlupd) leaving IDLE this cycle take priority over phyupd.
  assign pu_go_c = (pu_pend_q || phyupd_start) && (cu_q == CU_IDLE) && !cu_go_c &&
                   (lp_c_st == LP_IDLE) && (lp_d_st == LP_IDLE) &&
                   !lp_c_start && !lp_d_start && !lp_c_rej && !lp_d_rej;

  always_comb begin
    pu_d      = pu_q;
    pu_pend_d = pu_pend_q;
    pu_type_d = pu_type_q;
    pu_wait_d = pu_wait_q;
    pu_hold_d = pu_hold_q;
    pu_tmo_d  = pu_tmo_q;
    unique case (pu_q)
      PU_IDLE: begin
        if (phyupd_start) pu_type_d = phyupd_type_in;
        if (pu_go_c) begin
          pu_d      = PU_REQ;
          pu_pend_d = 1'b0;
          pu_wait_d = '0;
        end else if (phyupd_start) begin
          pu_pend_d = 1'b1;
        end
      end
      PU_REQ: begin
        if (dfi.phyupd_ack) begin
          pu_d      = PU_HOLD;
          pu_hold_d = HOLD_W'(PHYUPD_HOLD);
        end else if (pu_wait_q >= RESP_W'(TPHYUPD_RESP - 1)) begin
          pu_tmo_d = 1'b1;
        end else begin
          pu_wait_d = pu_wait_q + RESP_W'(1);
        end
      end
      PU_HOLD: begin
        if (pu_hold_q <= HOLD_W'(1)) begin
          pu_d      = PU_DROP;
          pu_hold_d = '0;
        end else begin
          pu_hold_d = pu_hold_q - HOLD_W'(1);
        end
      end
      PU_DROP: if (!dfi.phyupd_ack) pu_d = PU_IDLE;
      default: pu_d = PU_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pu_q      <= PU_IDLE;
      pu_pend_q <= 1'b0;
      pu_type_q <= PU_TYPE_0;
      pu_wait_q <= '0;
      pu_hold_q <= '0;
      pu_tmo_q  <= 1'b0;
      pu_req_q  <= 1'b0;
      pu_busy_q <= 1'b0;
    end else begin
      pu_q      <= pu_d;
      pu_pend_q <= pu_pend_d;
      pu_type_q <= pu_type_d;
      pu_wait_q <= pu_wait_d;
      pu_hold_q <= pu_hold_d;
      pu_tmo_q  <= pu_tmo_d;
      pu_req_q  <= (pu_d == PU_REQ) || (pu_d == PU_HOLD);
      pu_busy_q <= (pu_d != PU_IDLE);
    end
  end

  assign dfi.lp_ctrl_ack  = lp_c_ack;
  assign dfi.lp_data_ack  = lp_d_ack;
  assign dfi.ctrlupd_ack  = cu_ack_q & dfi.ctrlupd_req;
  assign dfi.phyupd_req   = pu_req_q;
  assign dfi.phyupd_type  = pu_type_q;
  assign upd_window       = dfi.ctrlupd_ack | (dfi.phyupd_ack & pu_req_q);
  assign phyupd_busy      = pu_busy_q;
  assign phyupd_timeout   = pu_tmo_q;

`ifdef WAV_DFI_PHY_RESP_STATS_EN
  logic       lp_c_ack_d1, lp_d_ack_d1;
  logic [1:0] lp_ack_inc, lp_rej_inc;
  logic       cu_ack_rise_c, pu_ack_rise_c;

  assign lp_ack_inc    = {1'b0, lp_c_ack & ~lp_c_ack_d1} + {1'b0, lp_d_ack & ~lp_d_ack_d1};
  assign lp_rej_inc    = {1'b0, lp_c_rej} + {1'b0, lp_d_rej};
  assign cu_ack_rise_c = (cu_q == CU_WAIT) && (cu_d == CU_ACK);
  assign pu_ack_rise_c = (pu_q == PU_REQ) && (pu_d == PU_HOLD);

  always_ff @(posedge clock) begin
    if (reset) begin
      lp_c_ack_d1     <= 1'b0;
      lp_d_ack_d1     <= 1'b0;
      lp_ack_cnt      <= '0;
      ctrlupd_ack_cnt <= '0;
      phyupd_cnt      <= '0;
      lp_rej_cnt      <= '0;
    end else begin
      lp_c_ack_d1     <= lp_c_ack;
      lp_d_ack_d1     <= lp_d_ack;
      lp_ack_cnt      <= sat_add(lp_ack_cnt, lp_ack_inc);
      ctrlupd_ack_cnt <= sat_add(ctrlupd_ack_cnt, {1'b0, cu_ack_rise_c});
      phyupd_cnt      <= sat_add(phyupd_cnt, {1'b0, pu_ack_rise_c});
      lp_rej_cnt      <= sat_add(lp_rej_cnt, lp_rej_inc);
    end
  end
`endif

endmodule

// File: tb/tb_wav_dfi_phy_responder.sv
// Self-checking bench for wav_dfi_phy_responder with randomized LP traffic and a timing model.
module tb_wav_dfi_phy_responder;
  import wav_dfi_phy_resp_pkg::*;

  localparam int LP_DLY = 4;
  localparam int CU_DLY = 2;
  localparam int RESP   = 16;
  localparam int HOLD   = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        lp_allow;
  logic        phyupd_start;
  pu_type_e    phyupd_type_in;
  logic [5:0]  lp_ctrl_wakeup_q, lp_data_wakeup_q;
  logic        upd_window, phyupd_busy, phyupd_timeout;
`ifdef WAV_DFI_PHY_RESP_STATS_EN
  logic [15:0] lp_ack_cnt, ctrlupd_ack_cnt, phyupd_cnt, lp_rej_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [5:0] m_wake_c = '0;
  logic [5:0] m_wake_d = '0;
  int m_rej = 0;

  wav_dfi_phy_responder_if dfi ();

  wav_dfi_phy_responder #(
    .LP_ACK_DLY(LP_DLY), .CTRLUPD_ACK_DLY(CU_DLY), .TPHYUPD_RESP(RESP), .PHYUPD_HOLD(HOLD)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .dfi              (dfi.slave),
    .lp_allow         (lp_allow),
    .phyupd_start     (phyupd_start),
    .phyupd_type_in   (phyupd_type_in),
    .lp_ctrl_wakeup_q (lp_ctrl_wakeup_q),
    .lp_data_wakeup_q (lp_data_wakeup_q),
    .upd_window       (upd_window),
    .phyupd_busy      (phyupd_busy),
    .phyupd_timeout   (phyupd_timeout)
`ifdef WAV_DFI_PHY_RESP_STATS_EN
    ,
    .lp_ack_cnt       (lp_ack_cnt),
    .ctrlupd_ack_cnt  (ctrlupd_ack_cnt),
    .phyupd_cnt       (phyupd_cnt),
    .lp_rej_cnt       (lp_rej_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: an accepted request acks on the DLY-th edge after the edge that first samples it.
  function automatic logic ack_model(input int edges, input int dly, input logic granted);
    return granted && (edges > dly);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++;
    if ({dfi.lp_ctrl_ack, dfi.lp_data_ack, dfi.ctrlupd_ack, dfi.phyupd_req} !== 4'b0) begin
      bad++; $display("FAIL reset_acks got=%b exp=0000",
                      {dfi.lp_ctrl_ack, dfi.lp_data_ack, dfi.ctrlupd_ack, dfi.phyupd_req});
    end
    total++;
    if ({lp_ctrl_wakeup_q, lp_data_wakeup_q} !== 12'h0) begin
      bad++; $display("FAIL reset_wakeup got=%h exp=000", {lp_ctrl_wakeup_q, lp_data_wakeup_q});
    end
    total++;
    if ({upd_window, phyupd_busy, phyupd_timeout, dfi.phyupd_type} !== 5'b0) begin
      bad++; $display("FAIL reset_misc got=%b exp=00000",
                      {upd_window, phyupd_busy, phyupd_timeout, dfi.phyupd_type});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lp_ctrl();
    lp_allow = 1'b1;
    dfi.lp_ctrl_wakeup = 6'h05;
    dfi.lp_ctrl_req = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      total++;
      if (dfi.lp_ctrl_ack !== ack_model(n, LP_DLY, 1'b1)) begin
        bad++; $display("FAIL lp_ctrl_ack edge=%0d got=%b exp=%b", n, dfi.lp_ctrl_ack,
                        ack_model(n, LP_DLY, 1'b1));
      end
    end
    m_wake_c = 6'h05;
    dfi.lp_ctrl_req = 1'b0;
    tick();
    total++;
    if (dfi.lp_ctrl_ack !== 1'b0) begin
      bad++; $display("FAIL lp_ctrl_ack_drop got=%b exp=0", dfi.lp_ctrl_ack);
    end
    total++;
    if (lp_ctrl_wakeup_q !== m_wake_c) begin
      bad++; $display("FAIL lp_ctrl_wakeup_q got=%h exp=%h", lp_ctrl_wakeup_q, m_wake_c);
    end
    tick();
  endtask

  task automatic test_lp_data_abort();
    int len;
    logic [5:0] w;
    len = int'($urandom_range(LP_DLY, 1));
    w = 6'($urandom);
    dfi.lp_data_wakeup = w;
    dfi.lp_data_req = 1'b1;
    for (int n = 1; n <= len; n++) begin
      tick();
      total++;
      if (dfi.lp_data_ack !== 1'b0) begin
        bad++; $display("FAIL lp_data_abort_hold edge=%0d got=%b exp=0", n, dfi.lp_data_ack);
      end
    end
    m_wake_d = w;
    dfi.lp_data_req = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      total++;
      if (dfi.lp_data_ack !== 1'b0) begin
        bad++; $display("FAIL lp_data_abort_after cyc=%0d got=%b exp=0", n, dfi.lp_data_ack);
      end
    end
    total++;
    if (lp_data_wakeup_q !== m_wake_d) begin
      bad++; $display("FAIL lp_data_wakeup_q got=%h exp=%h", lp_data_wakeup_q, m_wake_d);
    end
    // A fresh request must be accepted again after the abort.
    dfi.lp_data_req = 1'b1;
    repeat (LP_DLY + 1) tick();
    total++;
    if (dfi.lp_data_ack !== 1'b1) begin
      bad++; $display("FAIL lp_data_after_abort got=%b exp=1", dfi.lp_data_ack);
    end
    dfi.lp_data_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_lp_reject();
    lp_allow = 1'b0;
    dfi.lp_ctrl_wakeup = ~m_wake_c;
    dfi.lp_ctrl_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      total++;
      if (dfi.lp_ctrl_ack !== 1'b0) begin
        bad++; $display("FAIL lp_reject_ack edge=%0d got=%b exp=0", n, dfi.lp_ctrl_ack);
      end
    end
    m_rej++;
    total++;
    if (lp_ctrl_wakeup_q !== m_wake_c) begin
      bad++; $display("FAIL lp_reject_wakeup got=%h exp=%h", lp_ctrl_wakeup_q, m_wake_c);
    end
`ifdef WAV_DFI_PHY_RESP_STATS_EN
    total++;
    if (lp_rej_cnt !== 16'(m_rej)) begin
      bad++; $display("FAIL lp_rej_cnt got=%0d exp=%0d", lp_rej_cnt, m_rej);
    end
`endif
    dfi.lp_ctrl_req = 1'b0;
    tick();
    lp_allow = 1'b1;
    tick();
  endtask

  task automatic test_ctrlupd();
    int len;
    len = int'($urandom_range(8, 3));
    dfi.ctrlupd_req = 1'b1;
    for (int n = 1; n <= len; n++) begin
      tick();
      total++;
      if ({dfi.ctrlupd_ack, upd_window} !== {2{ack_model(n, CU_DLY, 1'b1)}}) begin
        bad++; $display("FAIL ctrlupd_ack edge=%0d got=%b%b exp=%b", n, dfi.ctrlupd_ack,
                        upd_window, ack_model(n, CU_DLY, 1'b1));
      end
    end
    dfi.ctrlupd_req = 1'b0;
    #1;
    total++;
    if ({dfi.ctrlupd_ack, upd_window} !== 2'b00) begin
      bad++; $display("FAIL ctrlupd_same_cycle_drop got=%b%b exp=00", dfi.ctrlupd_ack, upd_window);
    end
    repeat (2) tick();
  endtask

  task automatic test_phyupd();
    int dly;
    dly = int'($urandom_range(5, 1));
    phyupd_type_in = PU_TYPE_1;
    phyupd_start = 1'b1;
    tick();
    phyupd_start = 1'b0;
    phyupd_type_in = PU_TYPE_2;
    total++;
    if ({dfi.phyupd_req, phyupd_busy, dfi.phyupd_type} !== {2'b11, PU_TYPE_1}) begin
      bad++; $display("FAIL phyupd_rise got=%b%b%b exp=1101", dfi.phyupd_req, phyupd_busy,
                      dfi.phyupd_type);
    end
    repeat (dly) tick();
    dfi.phyupd_ack = 1'b1;
    for (int m = 1; m <= HOLD + 1; m++) begin
      tick();
      total++;
      if ({dfi.phyupd_req, upd_window, phyupd_busy} !== {{2{m <= HOLD}}, 1'b1}) begin
        bad++; $display("FAIL phyupd_hold m=%0d got=%b%b%b exp=%b%b1", m, dfi.phyupd_req,
                        upd_window, phyupd_busy, m <= HOLD, m <= HOLD);
      end
      total++;
      if (dfi.phyupd_type !== PU_TYPE_1) begin
        bad++; $display("FAIL phyupd_type_stable m=%0d got=%0d exp=1", m, dfi.phyupd_type);
      end
    end
    dfi.phyupd_ack = 1'b0;
    tick();
    total++;
    if ({phyupd_busy, phyupd_timeout} !== 2'b00) begin
      bad++; $display("FAIL phyupd_done got=%b%b exp=00", phyupd_busy, phyupd_timeout);
    end
    tick();
  endtask

  task automatic test_priority();
    pu_type_e t;
    t = pu_type_e'(2'($urandom_range(3, 0)));
    phyupd_type_in = t;
    phyupd_start = 1'b1;
    dfi.ctrlupd_req = 1'b1;
    tick();
    phyupd_start = 1'b0;
    total++;
    if ({dfi.phyupd_req, phyupd_busy} !== 2'b00) begin
      bad++; $display("FAIL prio_pending got=%b%b exp=00", dfi.phyupd_req, phyupd_busy);
    end
    repeat (CU_DLY) tick();
    total++;
    if ({dfi.ctrlupd_ack, dfi.phyupd_req} !== 2'b10) begin
      bad++; $display("FAIL prio_ctrlupd_wins got=%b%b exp=10", dfi.ctrlupd_ack, dfi.phyupd_req);
    end
    dfi.ctrlupd_req = 1'b0;
    tick();
    total++;
    if (dfi.phyupd_req !== 1'b0) begin
      bad++; $display("FAIL prio_cu_leaving got=%b exp=0", dfi.phyupd_req);
    end
    tick();
    total++;
    if ({dfi.phyupd_req, dfi.phyupd_type} !== {1'b1, t}) begin
      bad++; $display("FAIL prio_pending_fires got=%b%b exp=1%b", dfi.phyupd_req, dfi.phyupd_type, t);
    end
    dfi.phyupd_ack = 1'b1;
    repeat (HOLD + 1) tick();
    dfi.phyupd_ack = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    phyupd_type_in = PU_TYPE_3;
    phyupd_start = 1'b1;
    tick();
    phyupd_start = 1'b0;
    dfi.ctrlupd_req = 1'b1;
    for (int k = 1; k <= RESP + 4; k++) begin
      tick();
      total++;
      if ({phyupd_timeout, dfi.phyupd_req, dfi.ctrlupd_ack} !== {k >= RESP, 2'b10}) begin
        bad++; $display("FAIL timeout k=%0d got=%b%b%b exp=%b10", k, phyupd_timeout,
                        dfi.phyupd_req, dfi.ctrlupd_ack, k >= RESP);
      end
    end
    dfi.ctrlupd_req = 1'b0;
    tick();
    dfi.phyupd_ack = 1'b1;
    repeat (HOLD + 1) tick();
    dfi.phyupd_ack = 1'b0;
    repeat (2) tick();
    total++;
    if ({phyupd_timeout, phyupd_busy} !== 2'b10) begin
      bad++; $display("FAIL timeout_sticky got=%b%b exp=10", phyupd_timeout, phyupd_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] w;
    w = 6'($urandom) | 6'h01;
    dfi.lp_ctrl_wakeup = w;
    dfi.lp_ctrl_req = 1'b1;
    repeat (LP_DLY + 1) tick();
    total++;
    if ({dfi.lp_ctrl_ack, lp_ctrl_wakeup_q} !== {1'b1, w}) begin
      bad++; $display("FAIL reset_mid_pre got=%b_%h exp=1_%h", dfi.lp_ctrl_ack, lp_ctrl_wakeup_q, w);
    end
    reset = 1'b1;
    tick();
    total++;
    if ({dfi.lp_ctrl_ack, lp_ctrl_wakeup_q, phyupd_timeout} !== 8'h00) begin
      bad++; $display("FAIL reset_mid got=%b_%h_%b exp=0_00_0", dfi.lp_ctrl_ack,
                      lp_ctrl_wakeup_q, phyupd_timeout);
    end
    dfi.lp_ctrl_req = 1'b0;
    reset = 1'b0;
    m_wake_c = '0;
    m_wake_d = '0;
    m_rej = 0;
    repeat (2) tick();
  endtask

  task automatic test_random_lp();
    for (int it = 0; it < 12; it++) begin
      logic ch, granted, got;
      int len;
      logic [5:0] w;
      ch = 1'($urandom_range(1, 0));
      granted = 1'($urandom_range(1, 0));
      len = int'($urandom_range(10, 1));
      w = 6'($urandom);
      lp_allow = granted;
      if (ch) begin dfi.lp_data_wakeup = w; dfi.lp_data_req = 1'b1; end
      else begin dfi.lp_ctrl_wakeup = w; dfi.lp_ctrl_req = 1'b1; end
      for (int n = 1; n <= len; n++) begin
        tick();
        got = ch ? dfi.lp_data_ack : dfi.lp_ctrl_ack;
        total++;
        if (got !== ack_model(n, LP_DLY, granted)) begin
          bad++; $display("FAIL rand_lp it=%0d ch=%0d edge=%0d got=%b exp=%b", it, ch, n, got,
                          ack_model(n, LP_DLY, granted));
        end
      end
      if (granted && ch) m_wake_d = w;
      if (granted && !ch) m_wake_c = w;
      if (!granted) m_rej++;
      dfi.lp_ctrl_req = 1'b0;
      dfi.lp_data_req = 1'b0;
      tick();
      total++;
      if ({dfi.lp_ctrl_ack, dfi.lp_data_ack, lp_ctrl_wakeup_q, lp_data_wakeup_q} !==
          {2'b00, m_wake_c, m_wake_d}) begin
        bad++; $display("FAIL rand_lp_end it=%0d got=%b%b_%h_%h exp=00_%h_%h", it, dfi.lp_ctrl_ack,
                        dfi.lp_data_ack, lp_ctrl_wakeup_q, lp_data_wakeup_q, m_wake_c, m_wake_d);
      end
      tick();
    end
`ifdef WAV_DFI_PHY_RESP_STATS_EN
    total++;
    if (lp_rej_cnt !== 16'(m_rej)) begin
      bad++; $display("FAIL rand_lp_rej_cnt got=%0d exp=%0d", lp_rej_cnt, m_rej);
    end
`endif
    lp_allow = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    lp_allow = 1'b0;
    phyupd_start = 1'b0;
    phyupd_type_in = PU_TYPE_0;
    dfi.lp_ctrl_req = 1'b0;
    dfi.lp_ctrl_wakeup = '0;
    dfi.lp_data_req = 1'b0;
    dfi.lp_data_wakeup = '0;
    dfi.ctrlupd_req = 1'b0;
    dfi.phyupd_ack = 1'b0;
    test_reset();
    test_lp_ctrl();
    test_lp_data_abort();
    test_lp_reject();
    test_ctrlupd();
    test_phyupd();
    test_priority();
    test_timeout();
    test_reset_mid();
    test_random_lp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
